// File: rtl/victim_swap_ctrl.sv
// L1-side victim cache initiator: two-cycle lookup, L2 forward on miss, evict swap-in, fill response.
// All outputs are registered; next-cycle output values are derived from the next state.
module victim_swap_ctrl #(
    parameter int unsigned BLK_W = 512,
    parameter int unsigned TAG_W = 44,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 miss_valid,
    output logic                 miss_ready,
    input  logic [11:0]          miss_addr,
    input  logic [TAG_W-1:0]     miss_ptag,
    input  logic                 tlb_miss,
    input  logic                 evict_valid,
    input  logic [BLK_W-1:0]     evict_data,
    input  logic [TAG_W-1:0]     evict_ptag,
    input  logic [5:0]           evict_index,
    output logic [11:0]          vc_addr,
    output logic [TAG_W-1:0]     vc_ptag,
    output logic                 vc_we,
    output logic [BLK_W-1:0]     vc_wdata,
    output logic [TAG_W-1:0]     vc_wtag,
    output logic [5:0]           vc_windex,
    input  logic                 vc_found,
    input  logic [BLK_W-1:0]     vc_rdata,
    output logic                 l2_req_valid,
    input  logic                 l2_req_ready,
    output logic [TAG_W+6-1:0]   l2_req_addr,
    input  logic                 l2_resp_valid,
    input  logic [BLK_W-1:0]     l2_resp_data,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic                 rsp_abort,
    output logic [BLK_W-1:0]     rsp_data,
    output logic [CNT_W-1:0]     hit_count,
    output logic [CNT_W-1:0]     miss_count
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned L2A_W  = TAG_W + IDX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOK, S_CHECK, S_L2REQ, S_L2WAIT, S_SWAP, S_RESP
    } state_t;

    state_t              r_state, w_state_n;

    logic [IDX_W-1:0]    r_index;
    logic [TAG_W-1:0]    r_ptag;
    logic                r_evict_v;
    logic [BLK_W-1:0]    r_evict_data;
    logic [TAG_W-1:0]    r_evict_ptag;
    logic [IDX_W-1:0]    r_evict_index;
    logic [BLK_W-1:0]    r_fill;
    logic                r_hit;
    logic                r_abort;

    logic [BLK_W-1:0]    w_fill_n;
    logic                w_hit_n;
    logic                w_abort_n;
    logic                w_hit_inc;
    logic                w_miss_inc;
    logic                w_accept;

    logic                r_miss_ready,   w_miss_ready_n;
    logic [ADDR_W-1:0]   r_vc_addr,      w_vc_addr_n;
    logic [TAG_W-1:0]    r_vc_ptag,      w_vc_ptag_n;
    logic                r_vc_we,        w_vc_we_n;
    logic [BLK_W-1:0]    r_vc_wdata,     w_vc_wdata_n;
    logic [TAG_W-1:0]    r_vc_wtag,      w_vc_wtag_n;
    logic [IDX_W-1:0]    r_vc_windex,    w_vc_windex_n;
    logic                r_l2_req_valid, w_l2_req_valid_n;
    logic [L2A_W-1:0]    r_l2_req_addr,  w_l2_req_addr_n;
    logic                r_rsp_valid,    w_rsp_valid_n;
    logic                r_rsp_hit,      w_rsp_hit_n;
    logic                r_rsp_abort,    w_rsp_abort_n;
    logic [BLK_W-1:0]    r_rsp_data,     w_rsp_data_n;
    logic [CNT_W-1:0]    r_hit_count;
    logic [CNT_W-1:0]    r_miss_count;

    assign w_accept = (r_state == S_IDLE) && miss_valid;

    // Next state plus the output values the next state will present.
    always_comb begin
        w_state_n   = r_state;
        w_fill_n    = r_fill;
        w_hit_n     = r_hit;
        w_abort_n   = r_abort;
        w_hit_inc   = 1'b0;
        w_miss_inc  = 1'b0;
        w_vc_addr_n = '0;
        w_vc_ptag_n = '0;

        case (r_state)
            S_IDLE: begin
                if (miss_valid) begin
                    w_state_n   = S_LOOK;
                    w_vc_addr_n = miss_addr;
                    w_fill_n    = '0;
                    w_hit_n     = 1'b0;
                    w_abort_n   = 1'b0;
                end
            end
            S_LOOK: begin
                if (tlb_miss) begin
                    w_state_n = S_RESP;
                    w_abort_n = 1'b1;
                end else begin
                    w_state_n   = S_CHECK;
                    w_vc_ptag_n = r_ptag;
                end
            end
            S_CHECK: begin
                if (vc_found) begin
                    w_fill_n  = vc_rdata;
                    w_hit_n   = 1'b1;
                    w_hit_inc = 1'b1;
                    w_state_n = r_evict_v ? S_SWAP : S_RESP;
                end else begin
                    w_miss_inc = 1'b1;
                    w_state_n  = S_L2REQ;
                end
            end
            S_L2REQ: begin
                if (l2_req_ready) w_state_n = S_L2WAIT;
            end
            S_L2WAIT: begin
                if (l2_resp_valid) begin
                    w_fill_n  = l2_resp_data;
                    w_state_n = r_evict_v ? S_SWAP : S_RESP;
                end
            end
            S_SWAP:  w_state_n = S_RESP;
            S_RESP:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase

        w_miss_ready_n   = (w_state_n == S_IDLE);
        w_vc_we_n        = (w_state_n == S_SWAP);
        w_vc_wdata_n     = w_vc_we_n ? r_evict_data  : '0;
        w_vc_wtag_n      = w_vc_we_n ? r_evict_ptag  : '0;
        w_vc_windex_n    = w_vc_we_n ? r_evict_index : '0;
        w_l2_req_valid_n = (w_state_n == S_L2REQ);
        w_l2_req_addr_n  = w_l2_req_valid_n ? {r_ptag, r_index} : '0;
        w_rsp_valid_n    = (w_state_n == S_RESP);
        w_rsp_hit_n      = w_rsp_valid_n && w_hit_n;
        w_rsp_abort_n    = w_rsp_valid_n && w_abort_n;
        w_rsp_data_n     = (w_rsp_valid_n && !w_abort_n) ? w_fill_n : '0;
    end

    // State, flags, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_evict_v      <= 1'b0;
            r_hit          <= 1'b0;
            r_abort        <= 1'b0;
            r_miss_ready   <= 1'b1;
            r_vc_addr      <= '0;
            r_vc_ptag      <= '0;
            r_vc_we        <= 1'b0;
            r_vc_wdata     <= '0;
            r_vc_wtag      <= '0;
            r_vc_windex    <= '0;
            r_l2_req_valid <= 1'b0;
            r_l2_req_addr  <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_hit      <= 1'b0;
            r_rsp_abort    <= 1'b0;
            r_rsp_data     <= '0;
            r_hit_count    <= '0;
            r_miss_count   <= '0;
        end else begin
            r_state        <= w_state_n;
            r_hit          <= w_hit_n;
            r_abort        <= w_abort_n;
            r_miss_ready   <= w_miss_ready_n;
            r_vc_addr      <= w_vc_addr_n;
            r_vc_ptag      <= w_vc_ptag_n;
            r_vc_we        <= w_vc_we_n;
            r_vc_wdata     <= w_vc_wdata_n;
            r_vc_wtag      <= w_vc_wtag_n;
            r_vc_windex    <= w_vc_windex_n;
            r_l2_req_valid <= w_l2_req_valid_n;
            r_l2_req_addr  <= w_l2_req_addr_n;
            r_rsp_valid    <= w_rsp_valid_n;
            r_rsp_hit      <= w_rsp_hit_n;
            r_rsp_abort    <= w_rsp_abort_n;
            r_rsp_data     <= w_rsp_data_n;
            if (w_accept) r_evict_v <= evict_valid;
            if (w_hit_inc && (r_hit_count != '1))
                r_hit_count <= r_hit_count + CNT_W'(1);
            if (w_miss_inc && (r_miss_count != '1))
                r_miss_count <= r_miss_count + CNT_W'(1);
        end
    end

    // Access payload latches; only read while their access is in flight.
    always_ff @(posedge clk) begin
        r_fill <= w_fill_n;
        if (w_accept) begin
            r_index       <= miss_addr[11:6];
            r_ptag        <= miss_ptag;
            r_evict_data  <= evict_data;
            r_evict_ptag  <= evict_ptag;
            r_evict_index <= evict_index;
        end
    end

    assign miss_ready   = r_miss_ready;
    assign vc_addr      = r_vc_addr;
    assign vc_ptag      = r_vc_ptag;
    assign vc_we        = r_vc_we;
    assign vc_wdata     = r_vc_wdata;
    assign vc_wtag      = r_vc_wtag;
    assign vc_windex    = r_vc_windex;
    assign l2_req_valid = r_l2_req_valid;
    assign l2_req_addr  = r_l2_req_addr;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_hit      = r_rsp_hit;
    assign rsp_abort    = r_rsp_abort;
    assign rsp_data     = r_rsp_data;
    assign hit_count    = r_hit_count;
    assign miss_count   = r_miss_count;

endmodule

// File: tb/tb_victim_swap_ctrl.sv
// Self-checking bench for victim_swap_ctrl: directed vector table, reset/saturation sequences, random accesses.
module tb_victim_swap_ctrl;

    localparam int unsigned BLK_W = 512;
    localparam int unsigned TAG_W = 44;
    localparam int unsigned CNT_W = 2;
    localparam int          CMAX  = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               reset;
    logic               miss_valid, miss_ready;
    logic [11:0]        miss_addr;
    logic [TAG_W-1:0]   miss_ptag;
    logic               tlb_miss, evict_valid;
    logic [BLK_W-1:0]   evict_data;
    logic [TAG_W-1:0]   evict_ptag;
    logic [5:0]         evict_index;
    logic [11:0]        vc_addr;
    logic [TAG_W-1:0]   vc_ptag;
    logic               vc_we;
    logic [BLK_W-1:0]   vc_wdata;
    logic [TAG_W-1:0]   vc_wtag;
    logic [5:0]         vc_windex;
    logic               vc_found;
    logic [BLK_W-1:0]   vc_rdata;
    logic               l2_req_valid, l2_req_ready;
    logic [TAG_W+5:0]   l2_req_addr;
    logic               l2_resp_valid;
    logic [BLK_W-1:0]   l2_resp_data;
    logic               rsp_valid, rsp_hit, rsp_abort;
    logic [BLK_W-1:0]   rsp_data;
    logic [CNT_W-1:0]   hit_count, miss_count;

    victim_swap_ctrl #(.BLK_W(BLK_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready),
        .miss_addr(miss_addr), .miss_ptag(miss_ptag), .tlb_miss(tlb_miss),
        .evict_valid(evict_valid), .evict_data(evict_data),
        .evict_ptag(evict_ptag), .evict_index(evict_index),
        .vc_addr(vc_addr), .vc_ptag(vc_ptag), .vc_we(vc_we),
        .vc_wdata(vc_wdata), .vc_wtag(vc_wtag), .vc_windex(vc_windex),
        .vc_found(vc_found), .vc_rdata(vc_rdata),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_addr(l2_req_addr),
        .l2_resp_valid(l2_resp_valid), .l2_resp_data(l2_resp_data),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_abort(rsp_abort), .rsp_data(rsp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]      addr;
        logic [TAG_W-1:0] ptag;
        bit               ev;
        bit               tlb;
        bit               hit;
        int               rdly;
        int               sdly;
        bit               hold;
        int               exp_rsp;
        bit               exp_hit;
        bit               exp_abort;
        bit               exp_we;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int m_hit    = 0;
    int m_miss   = 0;

    task automatic chk_v(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] b;
        for (int i = 0; i < int'(BLK_W / 32); i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [TAG_W-1:0] rand_tag();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[TAG_W-1:0];
    endfunction

    function automatic vec_t mk(input logic [11:0] addr, input logic [TAG_W-1:0] ptag,
                                input bit ev, input bit tlb, input bit hit, input int rdly,
                                input int sdly, input bit hold, input int exp_rsp,
                                input bit exp_hit, input bit exp_abort, input bit exp_we);
        vec_t v;
        v.addr = addr; v.ptag = ptag; v.ev = ev; v.tlb = tlb; v.hit = hit;
        v.rdly = rdly; v.sdly = sdly; v.hold = hold; v.exp_rsp = exp_rsp;
        v.exp_hit = exp_hit; v.exp_abort = exp_abort; v.exp_we = exp_we;
        return v;
    endfunction

    // Reference rules: latency in cycles after accept, outcome flags and swap presence.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r = v;
        r.exp_abort = v.tlb;
        r.exp_hit   = !v.tlb && v.hit;
        r.exp_we    = !v.tlb && v.ev;
        if (v.tlb)      r.exp_rsp = 2;
        else if (v.hit) r.exp_rsp = 3 + int'(v.ev);
        else            r.exp_rsp = 5 + v.rdly + v.sdly + int'(v.ev);
        return r;
    endfunction

    // One access: drive the L1 side, play victim cache and L2, then compare against v's expectations.
    task automatic do_txn(input vec_t v);
        logic [BLK_W-1:0] vblk, lblk, edata, got_data;
        logic [TAG_W-1:0] etag;
        logic [5:0]       eidx;
        int  rsp_c = -1, we_n = 0, we_c = -1, l2_n = 0, l2_first = -1;
        bit  we_ok = 1, l2_ok = 1, vc_ok = 1, rdy_ok = 1;
        logic got_hit = 1'b0, got_abort = 1'b0;
        vblk = rand_blk(); lblk = rand_blk(); edata = rand_blk();
        etag = rand_tag(); eidx = 6'($urandom);
        got_data = '0;

        @(posedge clk); #1;
        chk_i("ready_at_accept", int'(miss_ready), 1);
        miss_valid = 1'b1; miss_addr = v.addr; miss_ptag = v.ptag;
        evict_valid = v.ev; evict_data = edata; evict_ptag = etag; evict_index = eidx;
        tlb_miss = 1'($urandom); vc_found = 1'($urandom);
        l2_req_ready = 1'b0; l2_resp_valid = 1'b0;
        if (!v.tlb) begin
            if (v.hit) begin if (m_hit < CMAX) m_hit++; end
            else begin if (m_miss < CMAX) m_miss++; end
        end

        for (int c = 1; c <= 60 && rsp_c < 0; c++) begin
            @(posedge clk); #1;
            if (!v.hold) miss_valid = 1'b0;
            miss_addr = 12'($urandom); miss_ptag = rand_tag();
            evict_valid = 1'($urandom); evict_data = rand_blk();
            evict_ptag = rand_tag(); evict_index = 6'($urandom);
            if (miss_ready) rdy_ok = 0;
            if (c == 1)      vc_ok &= (vc_addr == v.addr) && (vc_ptag == '0);
            else if (c == 2) vc_ok &= (vc_addr == '0) && (vc_ptag == (v.tlb ? '0 : v.ptag));
            else             vc_ok &= (vc_addr == '0) && (vc_ptag == '0);
            if (vc_we) begin
                we_n++; we_c = c;
                if (vc_wdata != edata || vc_wtag != etag || vc_windex != eidx) we_ok = 0;
            end
            if (l2_req_valid) begin
                if (l2_first < 0) l2_first = c;
                l2_n++;
                if (l2_req_addr != {v.ptag, v.addr[11:6]}) l2_ok = 0;
            end
            if (rsp_valid) begin
                rsp_c = c; got_hit = rsp_hit; got_abort = rsp_abort; got_data = rsp_data;
            end
            tlb_miss      = (c == 1) ? v.tlb : 1'($urandom);
            vc_found      = (c == 2) ? v.hit : 1'($urandom);
            vc_rdata      = (c == 2) ? vblk : rand_blk();
            l2_req_ready  = (c == 3 + v.rdly);
            l2_resp_valid = (c == 4 + v.rdly + v.sdly);
            l2_resp_data  = l2_resp_valid ? lblk : rand_blk();
        end
        tlb_miss = 1'b0; vc_found = 1'b0; l2_req_ready = 1'b0; l2_resp_valid = 1'b0;

        chk_i("rsp_cycle", rsp_c, v.exp_rsp);
        chk_i("rsp_hit", int'(got_hit), int'(v.exp_hit));
        chk_i("rsp_abort", int'(got_abort), int'(v.exp_abort));
        if (!v.exp_abort) chk_v("rsp_data", got_data, v.hit ? vblk : lblk);
        chk_i("vc_we_pulses", we_n, int'(v.exp_we));
        if (v.exp_we) chk_i("vc_we_cycle", we_c, v.exp_rsp - 1);
        chk_i("vc_we_fields", int'(we_ok), 1);
        chk_i("l2_req_cycles", l2_n, (!v.tlb && !v.hit) ? v.rdly + 1 : 0);
        if (!v.tlb && !v.hit) chk_i("l2_req_first", l2_first, 3);
        chk_i("l2_req_addr", int'(l2_ok), 1);
        chk_i("vc_addr_ptag", int'(vc_ok), 1);
        chk_i("miss_ready_busy", int'(rdy_ok), 1);
        chk_i("hit_count", int'(hit_count), m_hit);
        chk_i("miss_count", int'(miss_count), m_miss);
    endtask

    vec_t tbl[8];

    initial begin
        bit bad;
        reset = 1'b1; miss_valid = 1'b0; miss_addr = '0; miss_ptag = '0; tlb_miss = 1'b0;
        evict_valid = 1'b0; evict_data = '0; evict_ptag = '0; evict_index = '0;
        vc_found = 1'b0; vc_rdata = '0; l2_req_ready = 1'b0; l2_resp_valid = 1'b0; l2_resp_data = '0;

        //                addr    ptag      ev tlb hit rdly sdly hold rsp hit abt we
        tbl[0] = mk(12'h140, 44'h123,   1, 0,  1,  0,   0,   0,   4,  1,  0,  1);
        tbl[1] = mk(12'h2A7, 44'h456,   0, 0,  0,  3,   4,   0,  12,  0,  0,  0);
        tbl[2] = mk(12'h0C3, 44'h789,   1, 1,  0,  0,   0,   0,   2,  0,  1,  0);
        tbl[3] = mk(12'hFFF, 44'hABCDE, 0, 0,  1,  0,   0,   0,   3,  1,  0,  0);
        tbl[4] = mk(12'h801, 44'h11111, 1, 0,  0,  0,   0,   0,   6,  0,  0,  1);
        tbl[5] = mk(12'h03F, 44'h22222, 1, 0,  0,  1,   2,   0,   9,  0,  0,  1);
        tbl[6] = mk(12'h555, 44'h33333, 0, 0,  1,  0,   0,   1,   3,  1,  0,  0);
        tbl[7] = mk(12'hAAA, 44'h44444, 0, 0,  0,  0,   0,   0,   5,  0,  0,  0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_i("reset_miss_ready", int'(miss_ready), 1);
        chk_v("reset_outputs_zero",
              BLK_W'({vc_addr, vc_ptag, vc_we, vc_wtag, vc_windex, l2_req_valid, l2_req_addr,
                      rsp_valid, rsp_hit, rsp_abort, hit_count, miss_count}), '0);
        chk_v("reset_blocks_zero", vc_wdata | rsp_data, '0);

        foreach (tbl[i]) do_txn(tbl[i]);

        // Reset while waiting on L2: access is dropped, later L2 data is ignored.
        miss_valid = 1'b0;
        @(posedge clk); #1;
        miss_valid = 1'b1; miss_addr = 12'h9C4; miss_ptag = 44'h5A5A5;
        evict_valid = 1'b1; evict_data = rand_blk(); evict_ptag = rand_tag(); evict_index = 6'd9;
        @(posedge clk); #1; miss_valid = 1'b0; tlb_miss = 1'b0;
        @(posedge clk); #1; vc_found = 1'b0;
        @(posedge clk); #1;
        chk_i("rst_l2_req_up", int'(l2_req_valid), 1);
        l2_req_ready = 1'b1;
        @(posedge clk); #1; l2_req_ready = 1'b0; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        m_hit = 0; m_miss = 0;
        chk_v("rst_outputs_zero",
              BLK_W'({vc_addr, vc_ptag, vc_we, vc_wtag, vc_windex, l2_req_valid, l2_req_addr,
                      rsp_valid, rsp_hit, rsp_abort, hit_count, miss_count}), '0);
        chk_v("rst_blocks_zero", vc_wdata | rsp_data, '0);
        chk_i("rst_miss_ready", int'(miss_ready), 1);
        l2_resp_valid = 1'b1; l2_resp_data = rand_blk();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            l2_resp_valid = 1'b0;
            if (rsp_valid || vc_we || l2_req_valid || !miss_ready) bad = 1;
        end
        chk_i("rst_no_late_activity", int'(bad), 0);

        // Saturation: five victim hits on a 2-bit counter.
        for (int i = 0; i < 5; i++)
            do_txn(model(mk(12'($urandom), rand_tag(), 1'($urandom), 0, 1, 0, 0, 0, 0, 0, 0, 0)));
        chk_i("hit_count_saturated", int'(hit_count), 3);

        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v = mk(12'($urandom), rand_tag(), 1'($urandom), ($urandom % 5) == 0, 1'($urandom),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                   ($urandom % 4) == 0, 0, 0, 0, 0);
            do_txn(model(v));
        end
        miss_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/victim_swap_ctrl.md
# victim_swap_ctrl

L1-side initiator for the victim cache: on an L1 data-cache miss it issues the two-cycle victim lookup (index/offset first, physical tag one cycle later), then either captures the hit block or forwards the miss to L2. In both cases it writes the block L1 is evicting into the victim cache and returns the fill block to L1. It sits between the L1 dcache miss logic, the victim cache and the L2 request port.

## Interface
Parameters:
- BLK_W, 512, cache block width in bits
- TAG_W, 44, physical tag width
- CNT_W, 16, width of the hit/miss statistic counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- miss_valid  in  1  L1 presents a miss
- miss_ready  out  1  controller accepts a miss; high only in IDLE
- miss_addr  in  12  {index[11:6], offset[5:0]} of the missing access
- miss_ptag  in  TAG_W  physical tag of the miss; sampled at accept
- tlb_miss  in  1  TLB miss for the accepted access; valid at the end of the LOOK cycle
- evict_valid  in  1  L1 has a valid victim line to hand off; sampled at accept
- evict_data  in  BLK_W  evicted block
- evict_ptag  in  TAG_W  evicted block tag
- evict_index  in  6  evicted block index bits
- vc_addr  out  12  lookup address to the victim cache
- vc_ptag  out  TAG_W  physical tag to the victim cache, driven the cycle after vc_addr
- vc_we  out  1  victim cache write strobe, one cycle
- vc_wdata  out  BLK_W  write block
- vc_wtag  out  TAG_W  write tag
- vc_windex  out  6  write index bits
- vc_found  in  1  victim cache hit, valid in the CHECK cycle
- vc_rdata  in  BLK_W  victim block, valid with vc_found
- l2_req_valid  out  1  L2 fill request
- l2_req_ready  in  1  L2 accepts the request
- l2_req_addr  out  TAG_W+6  {ptag, index}
- l2_resp_valid  in  1  L2 fill data valid
- l2_resp_data  in  BLK_W  L2 fill block
- rsp_valid  out  1  one-cycle fill response to L1
- rsp_hit  out  1  fill came from the victim cache
- rsp_abort  out  1  access aborted (TLB miss); rsp_data is don't-care
- rsp_data  out  BLK_W  fill block
- hit_count, miss_count  out  CNT_W  saturating statistics

## Operation
- States: IDLE, LOOK, CHECK, L2REQ, L2WAIT, SWAP, RESP.
- IDLE: miss_ready=1. On miss_valid, latch miss_addr, miss_ptag, evict_valid, evict_data/ptag/index, then go to LOOK.
- LOOK: vc_addr = latched addr. If tlb_miss=1, go to RESP with abort. Otherwise go to CHECK.
- CHECK: vc_ptag = latched ptag. If vc_found, latch vc_rdata, set hit flag, increment hit_count, and go to SWAP. Otherwise increment miss_count and go to L2REQ.
- L2REQ: l2_req_valid=1 with l2_req_addr = {ptag, addr[11:6]}. Hold stable until l2_req_ready, then go to L2WAIT.
- L2WAIT: on l2_resp_valid, latch l2_resp_data and go to SWAP.
- SWAP: if the latched evict_valid=1, assert vc_we=1 for exactly one cycle with the evict fields. Then go to RESP. If evict_valid=0, there is no SWAP cycle: go directly to RESP.
- RESP: rsp_valid=1 for one cycle with rsp_hit, rsp_abort and rsp_data. Then go to IDLE.
- Abort path never asserts vc_we or l2_req_valid, and does not change the counters.
- Counters saturate at 2^CNT_W−1.
- vc_addr and vc_ptag are 0 outside LOOK and CHECK.
- vc_we is never asserted before CHECK completes, so a swap cannot overwrite the block being read.

## Timing
- Reset: state IDLE, every output 0, counters 0, miss_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation abandons the access. No pending vc_we, l2_req_valid or rsp_valid is issued.
- Accept at the edge ending cycle 0. LOOK is cycle 1, CHECK is cycle 2.
- Victim hit: SWAP in cycle 3, rsp_valid in cycle 4. Without an evict, rsp_valid is in cycle 3.
- Abort: rsp_valid in cycle 2.
- L2 path: l2_req_valid is first asserted in cycle 3. Response comes 1 cycle after l2_resp_valid, plus 1 more if a SWAP cycle is needed.
- l2_resp_valid outside L2WAIT is ignored.
- miss_valid outside IDLE is ignored; L1 must hold it until accepted.
- Throughput: one outstanding miss.

## Test plan
- Victim hit with evict: victim cache preloaded with tag 0x123/index 5; miss to addr 0x140, ptag 0x123, evict_valid=1. Expect vc_ptag=0x123 in cycle 2; vc_we=1 with evict fields in cycle 3; rsp_valid, rsp_hit=1 and rsp_data=preloaded block in cycle 4; hit_count=1.
- Victim miss, evict_valid=0: l2_req_addr={ptag, index}; l2_req_ready delayed 3 cycles and l2_resp_valid 5 cycles later. Expect no vc_we; rsp_valid 1 cycle after l2_resp_valid; rsp_hit=0; miss_count=1.
- TLB miss at LOOK: expect rsp_valid with rsp_abort=1 in cycle 2; no vc_we; no l2_req_valid; counters unchanged.
- Back-to-back: miss_valid held high for two accesses. Expect miss_ready=0 from accept to RESP, and the second accept in the cycle after RESP.
- Reset asserted during L2WAIT: expect all outputs 0 the next cycle, a later l2_resp_valid ignored, and no rsp_valid.
- Saturation: with CNT_W=2, 5 victim hits leave hit_count=3.
